sprite_plotter: RTL
===================

Name: sprite_plotter

Overview:
- Arbitrates per-object draw requests from the player and bee datapaths and drives the single vga_adapter pixel-write port.
- Each request names a top-left corner and a colour. The block expands it into a SIZE x SIZE square, writing one pixel per clock, then acknowledges the requester.
- Erasing an object is a request with colour 3'b000.
- Sits between the object datapaths (upstream) and vga_adapter (downstream; 160x120, 3-bit colour).

Parameters:
- N, 4, number of requesters (index 0 = player, 1..N-1 = bees).
- SIZE, 4, sprite edge length in pixels (1..8).
- X_MAX, 160, screen width; pixels with x >= X_MAX are suppressed.
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are suppressed.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester draw request, level; held high until the matching ack.
- req_x  in  N*8  packed top-left x; requester i uses bits [8i+7:8i].
- req_y  in  N*7  packed top-left y; requester i uses bits [7i+6:7i].
- req_colour  in  N*3  packed colour; requester i uses bits [3i+2:3i].
- ack  out  N  one-cycle pulse to the requester whose square has finished.
- busy  out  1  high from grant until ack, inclusive.
- x  out  8  pixel x to vga_adapter.
- y  out  7  pixel y to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  pixel write enable to vga_adapter.

Behaviour:
- Reset (async, reset_n low): state IDLE; ack=0, busy=0, plot=0, x=0, y=0, colour=0; round-robin pointer=0; all counters=0. Reset mid-draw abandons the square without ack. Requesters re-issue.
- States: IDLE, DRAW, DONE.

IDLE:
- If any req bit is set, grant the lowest index >= pointer, wrapping modulo N.
- Latch that requester's x, y and colour into internal registers. Clear dx and dy to 0.
- Go to DRAW with busy=1. The grant takes effect on the cycle after req is sampled high.

DRAW:
- One pixel per cycle; all outputs are registered.
- Drive x = base_x + dx and y = base_y + dy, computed at 9 and 8 bits respectively, then truncated to 8 and 7 bits.
- colour = latched colour.
- plot = 1 only if the unsigned sum is < X_MAX and < Y_MAX. Clipped pixels still consume their cycle with plot=0.
- Scan order is row-major: dx increments first; when dx = SIZE-1, dx resets to 0 and dy increments.
- After pixel (SIZE-1, SIZE-1), go to DONE.

DONE:
- plot=0. Pulse ack[granted]=1 for exactly one cycle.
- Set pointer = (granted+1) mod N.
- busy stays 1 during this cycle, then the block returns to IDLE.

Timing and request handling:
- Latency from req high (block idle) to first plot: 2 cycles. Pixel writes last SIZE*SIZE cycles, then the ack cycle.
- Minimum turnaround between squares is SIZE*SIZE + 2 cycles.
- Inputs are sampled only at grant. Changes to req_x, req_y or req_colour during DRAW are ignored.
- A req dropped during DRAW does not abort the draw; ack is still issued.
- A requester must drop req in the cycle after its ack. If req is still high in the IDLE cycle following the ack, it is treated as a new request.
- Simultaneous requests: the round-robin pointer decides. No requester is starved; a request waits at most N-1 squares.
- With no req, the block stays in IDLE and plot stays 0.

Test Plan:
- Single request: reset, then req[0]=1, x=10, y=20, colour=3'b111, SIZE=4. Expect 16 plot pulses in the order (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23), all colour 7. ack[0] pulses once, 18 cycles after the grant cycle.
- Clipping: req x=158, y=118. Expect plot=1 only for (158,118), (159,118), (158,119), (159,119); 12 cycles with plot=0; ack still issued.
- Round-robin: req=4'b1111 held and each dropped on its ack. Expect grant order 0,1,2,3. Re-raise req[0] and req[2] together → 0 then 2. With the pointer at 1, req[0] and req[3] together → 3 then 0.
- Input stability: after grant, change req_x, req_y and req_colour every cycle. Expect all 16 pixels to use the latched values; no extra ack.
- Reset mid-draw: assert reset_n=0 at pixel 7. Expect plot, busy and ack to go 0 immediately (async). After release, the block is IDLE with the pointer at 0, and a re-issued req redraws all 16 pixels.
- Erase: req colour=3'b000 at (0,0). Expect 16 plot pulses with colour 0; x and y never exceed 3.

Source files
------------

// File: rtl/sprite_plotter.sv
// Purpose : round-robin arbiter that expands per-object draw requests into SIZE x SIZE pixel writes.
// Latency : 2 cycles from req to first plot; SIZE*SIZE pixel cycles, then a 1-cycle ack pulse.
// Backpr. : req is level-held until ack; losing requesters simply wait (at most N-1 squares).
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req[N]                       per-requester draw request (level, held until ack)
//   req_x/req_y/req_colour       packed per-requester top-left corner and colour
//   ack[N]                       one-cycle completion pulse to the granted requester
//   busy                         high from grant through the ack cycle
//   x, y, colour, plot           registered pixel-write port to vga_adapter
module sprite_plotter #(
  parameter int N     = 4,
  parameter int SIZE  = 4,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*8-1:0] req_x,
  input  logic [N*7-1:0] req_y,
  input  logic [N*3-1:0] req_colour,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [7:0]     x,
  output logic [6:0]     y,
  output logic [2:0]     colour,
  output logic           plot
);

  localparam int         IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] LAST = 3'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [7:0]      base_x_q, base_x_d;
  logic [6:0]      base_y_q, base_y_d;
  logic [2:0]      base_c_q, base_c_d;
  logic [2:0]      dx_q, dx_d;
  logic [2:0]      dy_q, dy_d;

  logic [N-1:0]    ack_d;
  logic            busy_d;
  logic [7:0]      x_d;
  logic [6:0]      y_d;
  logic [2:0]      colour_d;
  logic            plot_d;

  logic [N-1:0]    req_eff;
  logic            found;
  logic [IW-1:0]   pick;
  logic [8:0]      sum_x;
  logic [7:0]      sum_y;

  // Sums are one bit wider than the screen coordinates so that squares
  // hanging off the right/bottom edge are recognised and clipped.
  assign sum_x = {1'b0, base_x_q} + {6'd0, dx_q};
  assign sum_y = {1'b0, base_y_q} + {5'd0, dy_q};

  // Round-robin pick: first pass looks at indices >= ptr, second pass wraps.
  // The requester being acked this cycle still holds req, so it is masked
  // out to avoid an immediate re-grant.
  always_comb begin
    req_eff = req & ~ack;
    found   = 1'b0;
    pick    = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_eff[i] && (IW'(i) >= ptr_q)) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_eff[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    base_c_d = base_c_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    ack_d    = '0;
    busy_d   = busy;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          state_d = DRAW;
          gnt_d   = pick;
          dx_d    = 3'd0;
          dy_d    = 3'd0;
          busy_d  = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (pick == IW'(i)) begin
              base_x_d = req_x[8*i +: 8];
              base_y_d = req_y[7*i +: 7];
              base_c_d = req_colour[3*i +: 3];
            end
          end
        end
      end

      DRAW: begin
        x_d      = sum_x[7:0];
        y_d      = sum_y[6:0];
        colour_d = base_c_q;
        plot_d   = (32'(sum_x) < X_MAX) && (32'(sum_y) < Y_MAX);
        if (dx_q == LAST) begin
          dx_d = 3'd0;
          if (dy_q == LAST) begin
            state_d = DONE;
          end else begin
            dy_d = dy_q + 3'd1;
          end
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end

      DONE: begin
        ack_d[gnt_q] = 1'b1;
        busy_d       = 1'b1;
        ptr_d        = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      base_c_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      base_c_q <= base_c_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      ack      <= ack_d;
      busy     <= busy_d;
      x        <= x_d;
      y        <= y_d;
      colour   <= colour_d;
      plot     <= plot_d;
    end
  end

endmodule
